spm_ctrl: RTL

//   Scratchpad memory (SPM) slave directly downstream of the CPU bus interface.

---
 rtl/spm_ctrl_pkg.sv | 22 ++
 rtl/spm_ctrl_if.sv | 22 ++
 rtl/spm_ctrl_ram.sv | 47 ++++
 rtl/spm_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/spm_ctrl_pkg.sv
// Shared definitions for the scratchpad memory controller: FSM state
// encodings, wait-counter width, bus direction codes, parity helper.
package spm_ctrl_pkg;

   localparam int SPM_WAIT_W = 3;

   // Bus direction encoding on spm_rw
   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   typedef enum logic [1:0] {
      SPM_STATE_IDLE   = 2'd0,
      SPM_STATE_ACCESS = 2'd1,
      SPM_STATE_DONE   = 2'd2
   } spm_state_e;

   // Even parity bit: XOR of all data bits
   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/spm_ctrl_if.sv
// CPU-side scratchpad bus. The CPU bus interface is the master, spm_ctrl
// the slave.
interface spm_ctrl_if;
   logic [29:0] spm_addr;
   logic        spm_as_;
   logic        spm_rw;
   logic [31:0] spm_wr_data;
   logic [31:0] spm_rd_data;
   logic        spm_rdy;
   logic        spm_busy;
   logic        spm_err;

   modport master (
      output spm_addr, spm_as_, spm_rw, spm_wr_data,
      input  spm_rd_data, spm_rdy, spm_busy, spm_err
   );

   modport slave (
      input  spm_addr, spm_as_, spm_rw, spm_wr_data,
      output spm_rd_data, spm_rdy, spm_busy, spm_err
   );
endinterface

// File: rtl/spm_ctrl_ram.sv
// Single-port synchronous scratchpad array with registered read.
// Optional feature macro: SPM_PARITY_EN -- stores an even-parity bit with
// each word and reports a mismatch on the word being read.
module spm_ctrl_ram
   import spm_ctrl_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              perr_o
);

`ifdef SPM_PARITY_EN
   logic [32:0] mem_q [0:(1<<ADDR_W)-1];
   logic [32:0] rword_q;

   // Write with generated parity; read the addressed word every cycle
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= {even_parity(wdata_i), wdata_i};
      end
      rword_q <= mem_q[addr_i];
   end

   assign rdata_o = rword_q[31:0];
   assign perr_o  = ^rword_q;
`else
   logic [31:0] mem_q [0:(1<<ADDR_W)-1];
   logic [31:0] rword_q;

   // Write port and registered read of the addressed word
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rword_q <= mem_q[addr_i];
   end

   assign rdata_o = rword_q;
   assign perr_o  = 1'b0;
`endif

endmodule

// File: rtl/spm_ctrl.sv
// Scratchpad memory controller: accepts one word access at a time, inserts
// WAIT_CYC wait states, stalls the pipeline via spm_busy and returns
// registered read data with a one-cycle spm_rdy pulse.
// Optional feature macro: SPM_PARITY_EN (parity error reported on spm_err).
module spm_ctrl
   import spm_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int WAIT_CYC = 1
) (
   input  logic     clk,
   input  logic     reset,
   spm_ctrl_if.slave bus
);

   spm_state_e            state_q;
   logic [SPM_WAIT_W-1:0] cnt_q;
   logic [29:0]           addr_q;
   logic                  rw_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rd_data_q;
   logic                  rdy_q;
   logic                  err_q;

   logic [ADDR_W-1:0]     ram_addr;
   logic [31:0]           ram_rdata;
   logic                  ram_perr;
   logic                  ram_we;
   logic                  in_range;
   logic                  commit;

   assign in_range = (addr_q[29:ADDR_W] == '0);
   assign commit   = (state_q == SPM_STATE_ACCESS) && (cnt_q == '0);
   assign ram_we   = commit && (rw_q == WRITE) && in_range && !reset;

   // In IDLE the array is read at the incoming bus address so the word is
   // already in the read register when ACCESS begins, even with WAIT_CYC=0.
   assign ram_addr = (state_q == SPM_STATE_IDLE) ? bus.spm_addr[ADDR_W-1:0]
                                                 : addr_q[ADDR_W-1:0];

   spm_ctrl_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata),
      .perr_o  (ram_perr)
   );

   // Access FSM: request latching, wait counting, completion outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SPM_STATE_IDLE;
         cnt_q     <= '0;
         rd_data_q <= '0;
         rdy_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            SPM_STATE_IDLE: begin
               if (!bus.spm_as_) begin
                  addr_q  <= bus.spm_addr;
                  rw_q    <= bus.spm_rw;
                  wdata_q <= bus.spm_wr_data;
                  cnt_q   <= SPM_WAIT_W'(WAIT_CYC);
                  state_q <= SPM_STATE_ACCESS;
               end
            end
            SPM_STATE_ACCESS: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  state_q <= SPM_STATE_DONE;
                  rdy_q   <= 1'b1;
                  if ((rw_q == READ) && in_range) begin
                     rd_data_q <= ram_rdata;
                  end else begin
                     rd_data_q <= '0;
                  end
                  err_q <= !in_range || ((rw_q == READ) && ram_perr);
               end
            end
            SPM_STATE_DONE: begin
               // The request still on the bus here is the completed one
               rdy_q   <= 1'b0;
               err_q   <= 1'b0;
               state_q <= SPM_STATE_IDLE;
            end
            default: begin
               state_q <= SPM_STATE_IDLE;
            end
         endcase
      end
   end

   assign bus.spm_rd_data = rd_data_q;
   assign bus.spm_rdy     = rdy_q;
   assign bus.spm_err     = err_q;
   assign bus.spm_busy    = !reset &&
                            (((state_q == SPM_STATE_IDLE) && !bus.spm_as_) ||
                             (state_q == SPM_STATE_ACCESS));

endmodule
